row_max_sub: RTL
================

ROW_MAX_SUB -- requirements
Module: row_max_sub

Interface
REQ-001 SHALL provide parameter D_W, default 16: signed two's-complement element width.
REQ-002 SHALL provide parameter BEATS, default 4: 16-element input beats per row, so the row length is 16*BEATS; legal range 2..64.
REQ-003 SHALL provide port I_CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port I_RST_N, input, 1: reset, synchronous, active-low.
REQ-005 SHALL provide port I_VALID, input, 1: upstream beat valid.
REQ-006 SHALL provide port O_READY, output, 1: block can accept an upstream beat.
REQ-007 SHALL provide port I_DATA, input, D_W x [0:15]: upstream beat of signed elements.
REQ-008 SHALL provide port O_VALID, output, 1: output beat valid.
REQ-009 SHALL provide port I_READY, input, 1: downstream ready.
REQ-010 SHALL provide port O_DATA, output, D_W x [0:15]: element minus row maximum, signed.
REQ-011 SHALL provide port O_MAX, output, D_W: row maximum register.
REQ-012 SHALL provide port O_LAST, output, 1: marks the final output beat of a row.

Function
REQ-013 SHALL implement two states: LOAD and EMIT.
REQ-014 In LOAD: O_READY=1 and O_VALID=0; a beat is accepted on a rising edge when I_VALID=1 and O_READY=1.
REQ-015 On each accepted beat, the block SHALL store the 16 elements into row buffer slot wr_idx.
REQ-016 On each accepted beat, max_reg SHALL be updated to the signed maximum of max_reg and all 16 I_DATA elements, in the same edge.
REQ-017 On each accepted beat, wr_idx SHALL increment.
REQ-018 When beat wr_idx=BEATS-1 is accepted, the block SHALL go to EMIT and clear wr_idx and rd_idx; O_VALID=1 in the next cycle, giving 1-cycle latency from the last accepted input to the first output.
REQ-019 In EMIT: O_READY=0; O_VALID=1; for each i, O_DATA[i] = buffer[rd_idx][i] - max_reg.
REQ-020 The subtraction SHALL be computed in D_W+1 bits and saturated to -2^(D_W-1) when below it; a result is never positive.
REQ-021 O_LAST SHALL be 1 only in EMIT with rd_idx=BEATS-1.
REQ-022 While O_VALID=1 and I_READY=0, O_DATA, O_LAST and O_MAX SHALL hold stable.
REQ-023 An output transfer occurs when O_VALID=1 and I_READY=1; on each transfer rd_idx SHALL increment.
REQ-024 On the transfer with O_LAST=1, the block SHALL return to LOAD and reset max_reg to -2^(D_W-1); O_READY=1 in the next cycle.
REQ-025 O_MAX SHALL equal max_reg at all times: the running max during LOAD, the final row max during EMIT.
REQ-026 Outside EMIT, O_DATA SHALL be driven to all zeros.
REQ-027 Rows SHALL NOT overlap: no input is accepted during EMIT, and I_VALID is ignored there.
REQ-028 Minimum row period SHALL be 2*BEATS cycles.
REQ-029 The comparison SHALL be signed; with equal maxima, the value is unaffected by element position.

Reset
REQ-030 While I_RST_N=0 at a rising edge, the block SHALL set: state LOAD, wr_idx=0, rd_idx=0, max_reg=-2^(D_W-1) (0x8000 for D_W=16).
REQ-031 The resulting reset outputs SHALL be O_READY=1, O_VALID=0, O_LAST=0, O_DATA=0, O_MAX=0x8000; buffer contents are don't-care.
REQ-032 Reset asserted mid-LOAD or mid-EMIT SHALL abandon the partial row; no output beat of that row appears after reset.

Verification
REQ-033 Basic row (D_W=16, BEATS=4): beats with element value = 4*beat+lane (0..63), I_READY=1 -> first O_VALID 1 cycle after the 4th accept; O_MAX=63; beat 0 O_DATA = -63..-48; beat 3 O_DATA = -15..0; O_LAST on beat 3.
REQ-034 Negative row: all elements 0xFFF0 except one 0xFFFE in beat 2 lane 9 -> O_MAX=0xFFFE, that lane outputs 0, all others output 0xFFF2 (-14).
REQ-035 Saturation: row holding 0x7FFF and 0x8000 -> element 0x8000 outputs 0x8000 (saturated), element 0x7FFF outputs 0.
REQ-036 Backpressure: I_READY toggling 1,0,0,1 during EMIT -> O_DATA, O_LAST and O_MAX stable while stalled; all 4 beats delivered exactly once in order; I_VALID=1 during EMIT is not accepted (O_READY=0).
REQ-037 Back-to-back rows: second row max 5 after first row max 100 -> second row O_MAX=5, confirming max_reg re-initialised; second row accepted the cycle after the first row's O_LAST transfer.
REQ-038 Reset after 2 accepted beats, then a fresh 4-beat row -> outputs reflect only the fresh row; O_MAX equals the fresh row's max.

Source files
------------

// File: rtl/row_max_sub.sv
// ---------------------------------------------------------------------------
// row_max_sub
// Buffers one row of BEATS x 16 signed elements while tracking the running
// signed maximum, then replays the row with every element reduced by the row
// maximum (saturated at the most negative D_W-bit value).
//
// Ports
//   I_CLK    : clock, all state updates on the rising edge
//   I_RST_N  : synchronous active-low reset
//   I_VALID  : upstream beat valid
//   O_READY  : block accepts an upstream beat (LOAD state)
//   I_DATA   : upstream beat, 16 signed D_W-bit lanes
//   O_VALID  : output beat valid (EMIT state)
//   I_READY  : downstream ready
//   O_DATA   : element minus row maximum, 16 signed lanes, zero outside EMIT
//   O_MAX    : current max register (running in LOAD, final in EMIT)
//   O_LAST   : final output beat of the row
// ---------------------------------------------------------------------------
module row_max_sub #(
    parameter int D_W   = 16,
    parameter int BEATS = 4
) (
    input  logic                  I_CLK,
    input  logic                  I_RST_N,
    input  logic                  I_VALID,
    output logic                  O_READY,
    input  logic [0:15][D_W-1:0]  I_DATA,
    output logic                  O_VALID,
    input  logic                  I_READY,
    output logic [0:15][D_W-1:0]  O_DATA,
    output logic [D_W-1:0]        O_MAX,
    output logic                  O_LAST
);

    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);
    localparam logic [D_W-1:0]   MIN_VAL  = {1'b1, {(D_W-1){1'b0}}};

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       wr_idx_q;
    logic [IDX_W-1:0]       rd_idx_q;
    logic [D_W-1:0]         max_q;
    logic [D_W-1:0]         beat_max_d;
    logic [0:15][D_W-1:0]   buf_q [BEATS];

    // Signed maximum of two elements.
    function automatic logic [D_W-1:0] smax(input logic [D_W-1:0] a,
                                            input logic [D_W-1:0] b);
        if ($signed(a) > $signed(b)) begin
            smax = a;
        end else begin
            smax = b;
        end
    endfunction

    // a - m in D_W+1 bits, clamped to the most negative D_W-bit value.
    // m is always >= a, so the result is never positive.
    function automatic logic [D_W-1:0] sat_sub(input logic [D_W-1:0] a,
                                               input logic [D_W-1:0] m);
        logic signed [D_W:0] diff;
        diff = $signed({a[D_W-1], a}) - $signed({m[D_W-1], m});
        if (diff < $signed({1'b1, MIN_VAL})) begin
            sat_sub = MIN_VAL;
        end else begin
            sat_sub = diff[D_W-1:0];
        end
    endfunction

    // Running maximum including the beat currently on I_DATA.
    always_comb begin
        beat_max_d = max_q;
        for (int i = 0; i < 16; i++) begin
            beat_max_d = smax(beat_max_d, I_DATA[i]);
        end
    end

    // Control FSM: indices, max register and LOAD/EMIT sequencing.
    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            state_q  <= ST_LOAD;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            max_q    <= MIN_VAL;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (I_VALID) begin
                        max_q <= beat_max_d;
                        if (wr_idx_q == LAST_IDX) begin
                            state_q  <= ST_EMIT;
                            wr_idx_q <= '0;
                            rd_idx_q <= '0;
                        end else begin
                            wr_idx_q <= wr_idx_q + 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (I_READY) begin
                        if (rd_idx_q == LAST_IDX) begin
                            state_q  <= ST_LOAD;
                            rd_idx_q <= '0;
                            max_q    <= MIN_VAL;
                        end else begin
                            rd_idx_q <= rd_idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_LOAD;
                    wr_idx_q <= '0;
                    rd_idx_q <= '0;
                    max_q    <= MIN_VAL;
                end
            endcase
        end
    end

    // Row buffer; contents need no reset since they are always rewritten
    // before being read.
    always_ff @(posedge I_CLK) begin
        if (state_q == ST_LOAD && I_VALID) begin
            buf_q[wr_idx_q] <= I_DATA;
        end
    end

    // Output data: max-subtracted elements during EMIT, zeros otherwise.
    always_comb begin
        O_DATA = '0;
        if (state_q == ST_EMIT) begin
            for (int i = 0; i < 16; i++) begin
                O_DATA[i] = sat_sub(buf_q[rd_idx_q][i], max_q);
            end
        end else begin
            O_DATA = '0;
        end
    end

    // Handshake flags decode directly from the state register.
    assign O_READY = (state_q == ST_LOAD);
    assign O_VALID = (state_q == ST_EMIT);
    assign O_LAST  = (state_q == ST_EMIT) && (rd_idx_q == LAST_IDX);
    assign O_MAX   = max_q;

endmodule
